// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared constants, lane-vector types and state enum for the vector memory paths
package vector_mem_pkg;

    localparam int LANES     = 3;
    localparam int DATA_W    = 18;
    localparam int ADDR_W    = 19;
    localparam int MEM_DEPTH = 307200;
    localparam int IDX_W     = $clog2(LANES);

    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;
    typedef logic [LANES-1:0][ADDR_W-1:0] addr_vec_t;
    typedef logic [IDX_W-1:0]             lane_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } vec_state_t;

    // Addresses at or beyond the 640x480 frame are not backed by memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/lane_pick.sv
// rtl/lane_pick.sv - combinational finder for the next enabled lane of a vector
module lane_pick
    import vector_mem_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  lane_idx_t        cur,
    input  logic             incl,
    output lane_idx_t        idx,
    output logic             last
);

    // Lowest enabled lane above cur (or at cur when incl); last means none was found.
    always_comb begin
        idx  = '0;
        last = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                idx  = lane_idx_t'(i);
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_write_serializer.sv
// rtl/vector_write_serializer.sv - serializes one 3-lane vector into single-port memory writes
module vector_write_serializer
    import vector_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES-1:0]  lane_mask,
    input  lane_vec_t         writeData,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    vec_state_t        state_q, state_d;
    lane_idx_t         ptr_q, ptr_d;
    lane_vec_t         data_q;
    addr_vec_t         addr_q;
    logic [LANES-1:0]  mask_q;
    logic              err_q, err_d;

    logic              we_d, done_d, aerr_d, busy_d, ready_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    logic              accept;
    addr_vec_t         in_addr_vec;
    lane_idx_t         first_idx, next_idx;
    logic              first_none, ptr_last;

    logic              issue;
    lane_idx_t         issue_idx;
    lane_vec_t         src_data;
    addr_vec_t         src_addr;

    assign accept      = in_valid & in_ready;
    assign in_addr_vec = {A3, A2, A1};

    // First lane of an incoming vector, searched from lane 0 inclusive.
    lane_pick u_first (
        .mask (lane_mask),
        .cur  ('0),
        .incl (1'b1),
        .idx  (first_idx),
        .last (first_none)
    );

    // Lane following the one currently on the memory port.
    lane_pick u_next (
        .mask (mask_q),
        .cur  (ptr_q),
        .incl (1'b0),
        .idx  (next_idx),
        .last (ptr_last)
    );

    // State, latched vector and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            in_ready  <= ready_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            addr_err  <= aerr_d;
            if (accept) begin
                data_q <= writeData;
                addr_q <= in_addr_vec;
                mask_q <= lane_mask;
            end
        end
    end

    // Next state: an empty mask skips straight to DONE; WRITE ends after the last enabled lane.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = first_none ? DONE : WRITE;
            WRITE:   if (ptr_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the first lane is issued straight from the inputs.
    always_comb begin
        ptr_d     = ptr_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        done_d    = 1'b0;
        aerr_d    = 1'b0;
        busy_d    = busy;
        ready_d   = in_ready;
        issue     = 1'b0;
        issue_idx = ptr_q;
        src_data  = data_q;
        src_addr  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    err_d    = 1'b0;
                    src_data = writeData;
                    src_addr = in_addr_vec;
                    if (first_none) begin
                        done_d = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        issue_idx = first_idx;
                        ptr_d     = first_idx;
                    end
                end
            end
            WRITE: begin
                if (ptr_last) begin
                    done_d = 1'b1;
                    aerr_d = err_q;
                end else begin
                    issue     = 1'b1;
                    issue_idx = next_idx;
                    ptr_d     = next_idx;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
        // An out-of-range lane still spends its cycle but leaves the port idle and flags the vector.
        if (issue) begin
            if (addr_in_range(src_addr[issue_idx])) begin
                we_d    = 1'b1;
                addr_d  = src_addr[issue_idx];
                wdata_d = src_data[issue_idx];
            end else begin
                err_d = 1'b1;
            end
        end
    end

endmodule
